// File: rtl/load_store_unit_if.sv
// Core/data-memory bundle for the load/store unit: request fields, completion
// status and the word-wide data-memory port.
interface load_store_unit_if;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] base;
    logic [31:0] offset;
    logic [31:0] store_data;
    logic [31:0] dmem_data_out;
    logic [31:0] dmem_address;
    logic [31:0] dmem_data_in;
    logic        dmem_wren;
    logic [31:0] load_data;
    logic        busy;
    logic        done;
    logic        fault;

    modport master (
        output start, is_store, funct3, base, offset, store_data, dmem_data_out,
        input  dmem_address, dmem_data_in, dmem_wren, load_data, busy, done, fault
    );

    modport slave (
        input  start, is_store, funct3, base, offset, store_data, dmem_data_out,
        output dmem_address, dmem_data_in, dmem_wren, load_data, busy, done, fault
    );
endinterface

// File: rtl/load_store_unit.sv
// Multicycle RV32I load/store sequencer: word-aligned data port, sub-word stores as read-merge-write.
// Latency fault 1, sw 2, loads/sb/sh 3 cycles to done; start is ignored while busy (incl. DONE/FAULT).
module load_store_unit (
    input  logic             clk,
    input  logic             reset,
    load_store_unit_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WAIT, S_MERGE, S_WR, S_FAULT, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  sel_q, sel_d;
    logic [31:0] sdata_q, sdata_d;
    logic [31:0] load_q, load_d;

    logic [31:0] eff;
    logic        legal;
    logic        aligned;
    logic [4:0]  shamt;
    logic [15:0] lane;
    logic [31:0] merge_mask;
    logic [31:0] merge_val;
    logic [31:0] merged;

    assign eff = bus.base + bus.offset;

    always_comb begin
        legal = 1'b0;
        case (bus.funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = ~bus.is_store;
            default:                legal = 1'b0;
        endcase
        aligned = 1'b1;
        case (bus.funct3[1:0])
            2'b01:   aligned = ~eff[0];
            2'b10:   aligned = (eff[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    // Lane shift shared by load extraction and the store merge.
    assign shamt = {sel_q, 3'b000};
    assign lane  = 16'(bus.dmem_data_out >> shamt);

    assign merge_mask = funct3_q[0] ? (32'h0000_FFFF << shamt) : (32'h0000_00FF << shamt);
    assign merge_val  = funct3_q[0] ? ({16'h0, sdata_q[15:0]} << shamt)
                                    : ({24'h0, sdata_q[7:0]} << shamt);
    assign merged     = (bus.dmem_data_out & ~merge_mask) | merge_val;

    assign bus.load_data = load_q;

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        sel_d      = sel_q;
        sdata_d    = sdata_q;
        load_d     = load_q;

        bus.dmem_address = 32'h0;
        bus.dmem_data_in = 32'h0;
        bus.dmem_wren    = 1'b0;
        bus.busy         = 1'b1;
        bus.done         = 1'b0;
        bus.fault        = 1'b0;

        case (state_q)
            S_IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) begin
                    is_store_d = bus.is_store;
                    funct3_d   = bus.funct3;
                    addr_d     = {eff[31:2], 2'b00};
                    sel_d      = eff[1:0];
                    sdata_d    = bus.store_data;
                    if (!legal || !aligned)
                        state_d = S_FAULT;
                    else if (bus.is_store && bus.funct3 == 3'b010)
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            S_RD: begin
                bus.dmem_address = addr_q;
                state_d = is_store_q ? S_MERGE : S_WAIT;
            end
            S_WAIT: begin
                bus.dmem_address = addr_q;
                case (funct3_q[1:0])
                    2'b00:   load_d = funct3_q[2] ? {24'h0, lane[7:0]}
                                                  : {{24{lane[7]}}, lane[7:0]};
                    2'b01:   load_d = funct3_q[2] ? {16'h0, lane}
                                                  : {{16{lane[15]}}, lane};
                    default: load_d = bus.dmem_data_out;
                endcase
                state_d = S_DONE;
            end
            S_MERGE: begin
                bus.dmem_address = addr_q;
                bus.dmem_wren    = 1'b1;
                bus.dmem_data_in = merged;
                state_d = S_DONE;
            end
            S_WR: begin
                bus.dmem_address = addr_q;
                bus.dmem_wren    = 1'b1;
                bus.dmem_data_in = sdata_q;
                state_d = S_DONE;
            end
            S_FAULT: begin
                bus.done  = 1'b1;
                bus.fault = 1'b1;
                state_d = S_IDLE;
            end
            S_DONE: begin
                bus.dmem_address = addr_q;
                bus.done = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= 32'h0;
            sel_q      <= 2'b00;
            sdata_q    <= 32'h0;
            load_q     <= 32'h0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            sel_q      <= sel_d;
            sdata_q    <= sdata_d;
            load_q     <= load_d;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-level reference model queues expected writes
// and completions; a negedge monitor pops and compares whenever the DUT writes or signals done.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    load_store_unit_if ifc ();

    load_store_unit dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ifc)
    );

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];

    always @(posedge clk) begin
        if (ifc.dmem_wren === 1'b1)
            mem[ifc.dmem_address[9:2]] <= ifc.dmem_data_in;
        ifc.dmem_data_out <= mem[ifc.dmem_address[9:2]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {int cyc; logic flt; logic [31:0] ld;} done_t;
    typedef struct {int cyc; logic [31:0] addr; logic [31:0] data;} wr_t;
    done_t dq[$];
    wr_t   wq[$];
    logic [31:0] last_ld = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: expected behaviour derived from byte-lane semantics.
    task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] b,
                         input logic [31:0] o, input logic [31:0] sd, input int k);
        logic [31:0]     eff, w, ld;
        int              sel, size;
        bit              ok;
        longint unsigned full, v;
        eff  = b + o;
        sel  = int'(eff[1:0]);
        size = 1 << f3[1:0];
        if (st) ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        else    ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (ok && (sel % size) != 0) ok = 0;
        w = ref_mem[eff[9:2]];
        if (!ok) begin
            dq.push_back('{k + 1, 1'b1, last_ld});
        end else if (st) begin
            for (int i = 0; i < size; i++)
                w[8*(sel+i) +: 8] = sd[8*i +: 8];
            ref_mem[eff[9:2]] = w;
            if (size == 4) begin
                wq.push_back('{k + 1, {eff[31:2], 2'b00}, w});
                dq.push_back('{k + 2, 1'b0, last_ld});
            end else begin
                wq.push_back('{k + 2, {eff[31:2], 2'b00}, w});
                dq.push_back('{k + 3, 1'b0, last_ld});
            end
        end else begin
            full = 64'd1 << (8 * size);
            v = (longint'(w) >> (8 * sel)) % full;
            if (!f3[2] && size < 4 && v >= full / 2)
                v = v + (64'h1_0000_0000 - full);
            ld = v[31:0];
            last_ld = ld;
            dq.push_back('{k + 3, 1'b0, ld});
        end
    endtask

    wr_t   mw;
    done_t md;
    always @(negedge clk) begin
        if (ifc.dmem_wren === 1'b1) begin
            if (wq.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_wren: addr 0x%08h data 0x%08h with no write expected (cycle %0d)",
                         ifc.dmem_address, ifc.dmem_data_in, cyc);
            end else begin
                mw = wq.pop_front();
                chk("wren_cycle", 32'(cyc), 32'(mw.cyc));
                chk("wr_addr", ifc.dmem_address, mw.addr);
                chk("wr_data", ifc.dmem_data_in, mw.data);
            end
        end
        if (ifc.done === 1'b1) begin
            if (dq.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_done: fault %0b with no completion expected (cycle %0d)",
                         ifc.fault, cyc);
            end else begin
                md = dq.pop_front();
                chk("done_cycle", 32'(cyc), 32'(md.cyc));
                chk("fault", {31'h0, ifc.fault}, {31'h0, md.flt});
                chk("load_data", ifc.load_data, md.ld);
            end
        end
    end

    task automatic scramble();
        ifc.is_store   = 1'($urandom);
        ifc.funct3     = 3'($urandom);
        ifc.base       = $urandom;
        ifc.offset     = $urandom;
        ifc.store_data = $urandom;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (ifc.busy !== 1'b0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_cmp++; n_err++;
            $display("FAIL idle_timeout: busy still %0b after 50 cycles", ifc.busy);
        end
    endtask

    task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] b,
                         input logic [31:0] o, input logic [31:0] sd);
        ifc.start = 1'b1; ifc.is_store = st; ifc.funct3 = f3;
        ifc.base = b; ifc.offset = o; ifc.store_data = sd;
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] b,
                         input logic [31:0] o, input logic [31:0] sd);
        wait_idle();
        drive(st, f3, b, o, sd);
        model(st, f3, b, o, sd, cyc);
        @(negedge clk);
        ifc.start = 1'b0;
        scramble();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_addr"},  ifc.dmem_address, 32'h0);
        chk({tag, "_wdata"}, ifc.dmem_data_in, 32'h0);
        chk({tag, "_ld"},    ifc.load_data, 32'h0);
        chk({tag, "_ctl"},   {28'h0, ifc.dmem_wren, ifc.busy, ifc.done, ifc.fault}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] b, o;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        rst_n = 1'b0;
        ifc.start = 1'b0;
        ifc.is_store = 1'b0; ifc.funct3 = 3'b0;
        ifc.base = 32'h0; ifc.offset = 32'h0; ifc.store_data = 32'h0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst_n = 1'b1;

        issue(1, 3'b010, 32'h100, 32'h4, 32'hDEADBEEF);
        issue(0, 3'b010, 32'h100, 32'h4, 32'h0);
        issue(1, 3'b010, 32'h100, 32'h4, 32'h80FF7F01);
        issue(0, 3'b000, 32'h100, 32'h7, 32'h0);
        issue(0, 3'b100, 32'h100, 32'h7, 32'h0);
        issue(0, 3'b001, 32'h100, 32'h6, 32'h0);
        issue(0, 3'b101, 32'h100, 32'h6, 32'h0);
        issue(1, 3'b010, 32'h100, 32'h4, 32'h11223344);
        issue(1, 3'b000, 32'h100, 32'h5, 32'h000000AA);
        issue(0, 3'b010, 32'h100, 32'h4, 32'h0);
        issue(1, 3'b001, 32'h100, 32'h6, 32'h0000BEEF);
        issue(0, 3'b010, 32'h100, 32'h4, 32'h0);
        issue(0, 3'b010, 32'h100, 32'h2, 32'h0);
        issue(0, 3'b011, 32'h100, 32'h4, 32'h0);
        issue(1, 3'b001, 32'h100, 32'h3, 32'h1234);
        issue(1, 3'b100, 32'h100, 32'h4, 32'h1234);
        issue(1, 3'b010, 32'hFFFFFFFC, 32'h8, 32'hCAFEF00D);
        issue(0, 3'b010, 32'h0, 32'h4, 32'h0);

        // start held for five cycles: accepted in cycle 0, ignored while busy, re-accepted in cycle 4
        wait_idle();
        for (int i = 0; i < 5; i++) begin
            drive(0, 3'b010, 32'h100, 32'h4, 32'h0);
            if (i == 0 || i == 4) model(0, 3'b010, 32'h100, 32'h4, 32'h0, cyc);
            @(negedge clk);
        end
        ifc.start = 1'b0;

        // Sub-word store aborted by reset during its read cycle
        wait_idle();
        drive(1, 3'b000, 32'h100, 32'h5, 32'h00000055);
        @(negedge clk);
        ifc.start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk_outputs_zero("midreset");
        rst_n = 1'b1;
        last_ld = 32'h0;
        repeat (2) @(negedge clk);
        chk("midreset_mem", mem[8'h41], ref_mem[8'h41]);

        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            b = 32'($urandom_range(0, 1023));
            o = 32'($urandom_range(0, 63)) - 32'd32;
            if ($urandom_range(0, 1) == 0) b = b & ~32'h3;
            if ($urandom_range(0, 30) == 0) b = 32'hFFFFFFF0 | (b & 32'hF);
            issue(1'($urandom), 3'($urandom), b, o, $urandom);
        end

        wait_idle();
        for (int t = 0; t < 20 && (dq.size() != 0 || wq.size() != 0); t++) @(negedge clk);
        chk("pending_done", 32'(dq.size()), 32'h0);
        chk("pending_wr", 32'(wq.size()), 32'h0);
        for (int i = 0; i < 256; i++)
            chk("final_mem", mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
